// File: rtl/alu_multicycle_pkg.sv
// rtl/alu_multicycle_pkg.sv - operator/state types and operator classification for alu_multicycle
package alu_multicycle_pkg;

   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,
      ALU_SUB   = 5'd1,
      ALU_SLTS  = 5'd2,
      ALU_SLTU  = 5'd3,
      ALU_AND   = 5'd4,
      ALU_OR    = 5'd5,
      ALU_XOR   = 5'd6,
      ALU_SLL   = 5'd7,
      ALU_SRL   = 5'd8,
      ALU_SRA   = 5'd9,
      ALU_MUL   = 5'd10,
      ALU_MULH  = 5'd11,
      ALU_MULHU = 5'd12,
      ALU_DIV   = 5'd13,
      ALU_DIVU  = 5'd14,
      ALU_REM   = 5'd15,
      ALU_REMU  = 5'd16
   } alu_opcode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } alu_state_e;

   function automatic logic is_mul_op(input alu_opcode_e op);
      return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
   endfunction

   function automatic logic is_div_op(input alu_opcode_e op);
      return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
   endfunction

   // Operators whose operands are two's complement and need magnitude/sign handling
   function automatic logic is_signed_md_op(input alu_opcode_e op);
      return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
   endfunction

   function automatic logic is_rem_op(input alu_opcode_e op);
      return (op == ALU_REM) || (op == ALU_REMU);
   endfunction

   function automatic logic is_known_op(input alu_opcode_e op);
      return op <= ALU_REMU;
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - shared iterative shift-add multiplier / restoring divider, one bit per cycle
module alu_muldiv_iter
   import alu_multicycle_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              flush,
   input  alu_opcode_e       op,
   input  logic [XLEN-1:0]   operand_a,
   input  logic [XLEN-1:0]   operand_b,
   output logic              last,
   output logic [XLEN-1:0]   result
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   // hi/lo: multiply = {accumulator, multiplier/product low}; divide = {remainder, dividend/quotient}
   logic [CNT_W-1:0]    cnt;
   logic [XLEN-1:0]     hi, lo, opb;
   logic                is_div, neg_res, neg_rem, sel_upper;

   logic                a_neg, b_neg;
   logic [XLEN-1:0]     abs_a, abs_b;
   logic [XLEN:0]       mul_sum, div_shift, div_diff;
   logic                q_bit;
   logic [XLEN-1:0]     hi_next, lo_next;
   logic [2*XLEN-1:0]   prod, prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix;

   always_comb begin
      a_neg = is_signed_md_op(op) & operand_a[XLEN-1];
      b_neg = is_signed_md_op(op) & operand_b[XLEN-1];
      abs_a = a_neg ? -operand_a : operand_a;
      abs_b = b_neg ? -operand_b : operand_b;
   end

   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      div_shift = {hi, lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opb};
      q_bit     = ~div_diff[XLEN];
      if (is_div) begin
         hi_next = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
         lo_next = {lo[XLEN-2:0], q_bit};
      end else begin
         hi_next = mul_sum[XLEN:1];
         lo_next = {mul_sum[0], lo[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         opb       <= '0;
         is_div    <= 1'b0;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
         sel_upper <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
      end else if (start) begin
         cnt     <= CNT_W'(XLEN);
         is_div  <= is_div_op(op);
         hi      <= '0;
         neg_res <= a_neg ^ b_neg;
         neg_rem <= a_neg;
         if (is_div_op(op)) begin
            lo        <= abs_a;
            opb       <= abs_b;
            sel_upper <= is_rem_op(op);
         end else begin
            lo        <= abs_b;
            opb       <= abs_a;
            sel_upper <= (op != ALU_MUL);
         end
      end else if (cnt != '0) begin
         hi  <= hi_next;
         lo  <= lo_next;
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign last = (cnt == CNT_W'(1));

   // Magnitudes were iterated; restore signs on the way out
   always_comb begin
      prod     = {hi, lo};
      prod_fix = neg_res ? -prod : prod;
      quo_fix  = neg_res ? -lo : lo;
      rem_fix  = neg_rem ? -hi : hi;
      if (is_div) begin
         result = sel_upper ? rem_fix : quo_fix;
      end else begin
         result = sel_upper ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - RV32IM ALU: registered single-cycle integer ops, iterative mul/div behind enable/ready/valid
module alu_multicycle
   import alu_multicycle_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_enable_ip,
   input  alu_opcode_e       alu_operator_ip,
   input  logic [XLEN-1:0]   alu_operand_a_ip,
   input  logic [XLEN-1:0]   alu_operand_b_ip,
   input  logic              alu_flush_ip,
   output logic              alu_ready_op,
   output logic [XLEN-1:0]   alu_result_op,
   output logic              alu_valid_op,
   output logic              alu_illegal_op
);

   localparam int              SH_W    = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   alu_state_e        state, next_state;
   logic [XLEN-1:0]   result_q, fast_result, md_result;
   logic              valid_q, illegal_q;
   logic              accept, div_zero, div_ovf, fast_path, md_start, md_last;
   logic [SH_W-1:0]   shamt;

   assign alu_ready_op = reset && (state == IDLE);
   assign accept       = alu_enable_ip && alu_ready_op && !alu_flush_ip;

   always_comb begin
      shamt       = alu_operand_b_ip[SH_W-1:0];
      div_zero    = (alu_operand_b_ip == '0);
      div_ovf     = (alu_operand_a_ip == INT_MIN) && (alu_operand_b_ip == '1);
      fast_result = '0;
      case (alu_operator_ip)
         ALU_ADD:  fast_result = alu_operand_a_ip + alu_operand_b_ip;
         ALU_SUB:  fast_result = alu_operand_a_ip - alu_operand_b_ip;
         ALU_SLTS: fast_result = {{(XLEN-1){1'b0}}, $signed(alu_operand_a_ip) < $signed(alu_operand_b_ip)};
         ALU_SLTU: fast_result = {{(XLEN-1){1'b0}}, alu_operand_a_ip < alu_operand_b_ip};
         ALU_AND:  fast_result = alu_operand_a_ip & alu_operand_b_ip;
         ALU_OR:   fast_result = alu_operand_a_ip | alu_operand_b_ip;
         ALU_XOR:  fast_result = alu_operand_a_ip ^ alu_operand_b_ip;
         ALU_SLL:  fast_result = alu_operand_a_ip << shamt;
         ALU_SRL:  fast_result = alu_operand_a_ip >> shamt;
         ALU_SRA:  fast_result = $signed(alu_operand_a_ip) >>> shamt;
         // Only reached for divide-by-zero or signed overflow; the iterator handles the rest
         ALU_DIV, ALU_DIVU: fast_result = div_zero ? '1 : alu_operand_a_ip;
         ALU_REM, ALU_REMU: fast_result = div_zero ? alu_operand_a_ip : '0;
         default:  fast_result = '0;
      endcase
   end

   assign fast_path = is_div_op(alu_operator_ip)
                    ? (div_zero || (is_signed_md_op(alu_operator_ip) && div_ovf))
                    : !is_mul_op(alu_operator_ip);
   assign md_start  = accept && !fast_path;

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (md_start) begin
               if (is_div_op(alu_operator_ip)) next_state = DIV;
               else                            next_state = MUL;
            end
         end
         MUL, DIV: if (md_last) next_state = DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
      if (alu_flush_ip) next_state = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         result_q  <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state     <= next_state;
         valid_q   <= accept && fast_path;
         illegal_q <= accept && !is_known_op(alu_operator_ip);
         if (accept && fast_path) begin
            result_q <= fast_result;
         end else if (state == DONE) begin
            result_q <= md_result;
         end
      end
   end

   // DONE presents the fixed-up iterator result directly; result_q keeps it afterwards
   assign alu_valid_op   = valid_q || (state == DONE);
   assign alu_illegal_op = illegal_q;
   assign alu_result_op  = (state == DONE) ? md_result : result_q;

   alu_muldiv_iter #(
      .XLEN (XLEN)
   ) u_muldiv (
      .clk       (clk),
      .reset     (reset),
      .start     (md_start),
      .flush     (alu_flush_ip),
      .op        (alu_operator_ip),
      .operand_a (alu_operand_a_ip),
      .operand_b (alu_operand_b_ip),
      .last      (md_last),
      .result    (md_result)
   );

endmodule
